// File: rtl/laser_search_sched.sv
// laser_search_sched: sequencing controller for the two-circle laser coverage search.
// Runs an alternating grid sweep. Each sweep moves one circle over all 256 grid
// positions while the other circle stays at its best position. Coverage of the
// point buffer is counted with a built-in distance datapath. The best centre
// pair is kept, and DONE pulses when a full pass brings no improvement or when
// MAX_PASS passes have run.
// Optional feature: define LASER_EARLY_EXIT_EN to finish as soon as one pair
// covers every point.

module laser_search_sched #(
    parameter int NPTS     = 40,
    parameter int R2       = 16,
    parameter int MAX_PASS = 8,
    parameter int INIT_C1X = 0,
    parameter int INIT_C1Y = 0,
    parameter int INIT_C2X = 0,
    parameter int INIT_C2Y = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    output logic [5:0] pt_addr,
    input  logic [3:0] pt_x,
    input  logic [3:0] pt_y,
    output logic       busy,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic [5:0] best_cnt,
    output logic       DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_DRAIN,
        S_CMP,
        S_SWAP,
        S_FIN
    } state_t;

    typedef enum logic {
        SWEEP_C1,
        SWEEP_C2
    } sweep_t;

    localparam logic [5:0] LAST_ADDR = 6'(NPTS - 1);
    localparam logic [8:0] R2_LIM    = 9'(R2);
    localparam logic [7:0] LAST_PASS = 8'(MAX_PASS);
    localparam logic [3:0] I_C1X     = 4'(INIT_C1X);
    localparam logic [3:0] I_C1Y     = 4'(INIT_C1Y);
    localparam logic [3:0] I_C2X     = 4'(INIT_C2X);
    localparam logic [3:0] I_C2Y     = 4'(INIT_C2Y);
`ifdef LASER_EARLY_EXIT_EN
    localparam logic [5:0] FULL_CNT  = 6'(NPTS);
`endif

    state_t      state_q, state_d;
    sweep_t      sweep_q, sweep_d;
    logic [7:0]  pass_q, pass_d;
    logic [7:0]  cand_q, cand_d;
    logic [5:0]  pass_start_q, pass_start_d;
    logic [5:0]  cur_cnt_q, cur_cnt_d;
    logic [5:0]  pt_addr_q, pt_addr_d;
    logic [3:0]  c1x_q, c1x_d, c1y_q, c1y_d;
    logic [3:0]  c2x_q, c2x_d, c2y_q, c2y_d;
    logic [5:0]  best_cnt_q, best_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  eval_c1x, eval_c1y, eval_c2x, eval_c2y;
    logic        pt_hit;
    logic        acc_en;
    logic        early_exit;

    // True when point (px,py) lies inside the circle centred at (cx,cy).
    function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] dx2;
        logic [7:0] dy2;
        logic [8:0] d2;
        dx  = (px >= cx) ? (px - cx) : (cx - px);
        dy  = (py >= cy) ? (py - cy) : (cy - py);
        dx2 = {4'd0, dx} * {4'd0, dx};
        dy2 = {4'd0, dy} * {4'd0, dy};
        d2  = {1'b0, dx2} + {1'b0, dy2};
        return (d2 <= R2_LIM);
    endfunction

    // Coverage datapath: the swept circle sits at the candidate and the other at its best.
    always_comb begin
        eval_c1x = c1x_q;
        eval_c1y = c1y_q;
        eval_c2x = c2x_q;
        eval_c2y = c2y_q;
        if (sweep_q == SWEEP_C1) begin
            eval_c1x = cand_q[3:0];
            eval_c1y = cand_q[7:4];
        end else begin
            eval_c2x = cand_q[3:0];
            eval_c2y = cand_q[7:4];
        end
        // A point inside both circles is still one covered point.
        pt_hit = in_circle(pt_x, pt_y, eval_c1x, eval_c1y)
               | in_circle(pt_x, pt_y, eval_c2x, eval_c2y);
        // Read data trails the address by one cycle; the first EVAL cycle has
        // nothing to count yet, and DRAIN collects the last point.
        acc_en = ((state_q == S_EVAL) && (pt_addr_q != 6'd0)) || (state_q == S_DRAIN);
    end

    // Next-state and next-output logic for the search sequencer.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
        state_d      = state_q;
        sweep_d      = sweep_q;
        pass_d       = pass_q;
        cand_d       = cand_q;
        pass_start_d = pass_start_q;
        cur_cnt_d    = cur_cnt_q;
        pt_addr_d    = pt_addr_q;
        c1x_d        = c1x_q;
        c1y_d        = c1y_q;
        c2x_d        = c2x_q;
        c2y_d        = c2y_q;
        best_cnt_d   = best_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        early_exit   = 1'b0;

        if (acc_en && pt_hit) begin
            cur_cnt_d = cur_cnt_q + 6'd1;
        end

        case (state_q)
            // FIN has busy low, so a start arriving there is accepted as well.
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d      = S_EVAL;
                    busy_d       = 1'b1;
                    c1x_d        = I_C1X;
                    c1y_d        = I_C1Y;
                    c2x_d        = I_C2X;
                    c2y_d        = I_C2Y;
                    best_cnt_d   = 6'd0;
                    sweep_d      = SWEEP_C1;
                    pass_d       = 8'd0;
                    cand_d       = 8'd0;
                    pass_start_d = 6'd0;
                    cur_cnt_d    = 6'd0;
                    pt_addr_d    = 6'd0;
                end
            end

            S_EVAL: begin
                if (pt_addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    pt_addr_d = pt_addr_q + 6'd1;
                end
            end

            S_DRAIN: begin
                state_d = S_CMP;
            end

            S_CMP: begin
                // Strictly greater: a tie keeps the pair found earlier.
                if (cur_cnt_q > best_cnt_q) begin
                    best_cnt_d = cur_cnt_q;
                    if (sweep_q == SWEEP_C1) begin
                        c1x_d = cand_q[3:0];
                        c1y_d = cand_q[7:4];
                    end else begin
                        c2x_d = cand_q[3:0];
                        c2y_d = cand_q[7:4];
                    end
                end
`ifdef LASER_EARLY_EXIT_EN
                early_exit = (best_cnt_d == FULL_CNT);
`endif
                if (early_exit) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (cand_q != 8'hFF) begin
                    cand_d    = cand_q + 8'd1;
                    cur_cnt_d = 6'd0;
                    pt_addr_d = 6'd0;
                    state_d   = S_EVAL;
                end else begin
                    state_d = S_SWAP;
                end
            end

            S_SWAP: begin
                if (sweep_q == SWEEP_C1) begin
                    sweep_d   = SWEEP_C2;
                    cand_d    = 8'd0;
                    cur_cnt_d = 6'd0;
                    pt_addr_d = 6'd0;
                    state_d   = S_EVAL;
                end else begin
                    pass_d = pass_q + 8'd1;
                    // Converged (no gain over the whole pass) or out of passes.
                    if ((best_cnt_q == pass_start_q) || ((pass_q + 8'd1) == LAST_PASS)) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pass_start_d = best_cnt_q;
                        sweep_d      = SWEEP_C1;
                        cand_d       = 8'd0;
                        cur_cnt_d    = 6'd0;
                        pt_addr_d    = 6'd0;
                        state_d      = S_EVAL;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; a synchronous reset aborts any search in progress.
    always_ff @(posedge CLK) begin
        // NOTE: this design has no memory array, so every flop takes a reset value.
        if (RST) begin
            state_q      <= S_IDLE;
            sweep_q      <= SWEEP_C1;
            pass_q       <= 8'd0;
            cand_q       <= 8'd0;
            pass_start_q <= 6'd0;
            cur_cnt_q    <= 6'd0;
            pt_addr_q    <= 6'd0;
            c1x_q        <= I_C1X;
            c1y_q        <= I_C1Y;
            c2x_q        <= I_C2X;
            c2y_q        <= I_C2Y;
            best_cnt_q   <= 6'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            pass_q       <= pass_d;
            cand_q       <= cand_d;
            pass_start_q <= pass_start_d;
            cur_cnt_q    <= cur_cnt_d;
            pt_addr_q    <= pt_addr_d;
            c1x_q        <= c1x_d;
            c1y_q        <= c1y_d;
            c2x_q        <= c2x_d;
            c2y_q        <= c2y_d;
            best_cnt_q   <= best_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign pt_addr  = pt_addr_q;
    assign busy     = busy_q;
    assign C1X      = c1x_q;
    assign C1Y      = c1y_q;
    assign C2X      = c2x_q;
    assign C2Y      = c2y_q;
    assign best_cnt = best_cnt_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_laser_search_sched.sv
// Testbench for laser_search_sched. A small point buffer keeps the full searches
// short. A second instance with MAX_PASS=1 shares the stimulus.

module tb_laser_search_sched;

    localparam int NPTS       = 6;
    localparam int R2         = 16;
    localparam int MAX_PASS   = 3;
    localparam int CAND_CYC   = NPTS + 2;
    localparam int WAIT_LIMIT = 20000;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;

    logic [5:0] pt_addr, pt_addr_b;
    logic [3:0] pt_x, pt_y, pt_x_b, pt_y_b;
    logic       busy, done, busy_b, done_b;
    logic [3:0] c1x, c1y, c2x, c2y;
    logic [3:0] c1x_b, c1y_b, c2x_b, c2y_b;
    logic [5:0] best_cnt, best_cnt_b;

    logic [3:0] mem_x [64];
    logic [3:0] mem_y [64];

    int n_checks = 0;
    int n_errors = 0;
    int mp1_busy_cyc = 0;
    int mp1_done_cnt = 0;

    always #5 clk = ~clk;

    // Point RAM: read data appears one cycle after the address, one port per instance.
    always @(posedge clk) begin
        pt_x   <= mem_x[pt_addr];
        pt_y   <= mem_y[pt_addr];
        pt_x_b <= mem_x[pt_addr_b];
        pt_y_b <= mem_y[pt_addr_b];
    end

    // Busy-cycle and DONE counters for the single-pass instance.
    always @(negedge clk) begin
        if (busy_b) mp1_busy_cyc++;
        if (done_b) mp1_done_cnt++;
    end

    laser_search_sched #(.NPTS(NPTS), .R2(R2), .MAX_PASS(MAX_PASS)) dut (
        .CLK(clk), .RST(rst), .start(start), .pt_addr(pt_addr), .pt_x(pt_x), .pt_y(pt_y),
        .busy(busy), .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y),
        .best_cnt(best_cnt), .DONE(done)
    );

    laser_search_sched #(.NPTS(NPTS), .R2(R2), .MAX_PASS(1)) dut_mp1 (
        .CLK(clk), .RST(rst), .start(start), .pt_addr(pt_addr_b), .pt_x(pt_x_b), .pt_y(pt_y_b),
        .busy(busy_b), .C1X(c1x_b), .C1Y(c1y_b), .C2X(c2x_b), .C2Y(c2y_b),
        .best_cnt(best_cnt_b), .DONE(done_b)
    );

    // ---------------- reference model ----------------

    function automatic bit covers(int px, int py, int cx, int cy);
        return ((px - cx) * (px - cx) + (py - cy) * (py - cy)) <= R2;
    endfunction

    // Plays the whole search with plain loops over passes, sweeps and candidates.
    // Reports the final pair/count and the number of busy cycles before DONE.
    task automatic model_run(input int max_pass, output logic [21:0] res, output int cycles);
        int  b1x, b1y, b2x, b2y, best, start_best, cnt;
        bit  fin;
        b1x = 0; b1y = 0; b2x = 0; b2y = 0;
        best = 0; start_best = 0; fin = 1'b0; cycles = 0;
        for (int pass = 0; !fin; pass++) begin
            for (int sweep = 0; sweep < 2 && !fin; sweep++) begin
                for (int cand = 0; cand < 256 && !fin; cand++) begin
                    int ax, ay, bx, by;
                    ax = (sweep == 0) ? cand % 16 : b1x;
                    ay = (sweep == 0) ? cand / 16 : b1y;
                    bx = (sweep == 1) ? cand % 16 : b2x;
                    by = (sweep == 1) ? cand / 16 : b2y;
                    cnt = 0;
                    for (int p = 0; p < NPTS; p++) begin
                        if (covers(mem_x[p], mem_y[p], ax, ay) || covers(mem_x[p], mem_y[p], bx, by))
                            cnt++;
                    end
                    cycles += CAND_CYC;
                    if (cnt > best) begin
                        best = cnt;
                        if (sweep == 0) begin b1x = cand % 16; b1y = cand / 16; end
                        else            begin b2x = cand % 16; b2y = cand / 16; end
`ifdef LASER_EARLY_EXIT_EN
                        if (best == NPTS) fin = 1'b1;
`endif
                    end
                end
                if (!fin) begin
                    cycles += 1;
                    if (sweep == 1) begin
                        if (best == start_best || pass + 1 == max_pass) fin = 1'b1;
                        else start_best = best;
                    end
                end
            end
        end
        res = {4'(b1x), 4'(b1y), 4'(b2x), 4'(b2y), 6'(best)};
    endtask

    // ---------------- stimulus helpers ----------------

    // Pulses start, counts busy cycles until DONE (bounded), then watches a few more cycles.
    task automatic launch(output int busy_cyc, output int n_done, output logic busy_at_done);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cyc = 0; n_done = 0; busy_at_done = 1'bx;
        for (int i = 0; i < WAIT_LIMIT && n_done == 0; i++) begin
            if (done) begin
                n_done = 1;
                busy_at_done = busy;
            end else begin
                if (busy) busy_cyc++;
                @(posedge clk); #1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
    endtask

    task automatic load_corners();
        mem_x[0] = 4'd0;  mem_y[0] = 4'd0;
        mem_x[1] = 4'd15; mem_y[1] = 4'd15;
        mem_x[2] = 4'd0;  mem_y[2] = 4'd15;
        mem_x[3] = 4'd15; mem_y[3] = 4'd0;
        mem_x[4] = 4'($urandom_range(0, 15)); mem_y[4] = 4'($urandom_range(0, 15));
        mem_x[5] = 4'($urandom_range(0, 15)); mem_y[5] = 4'($urandom_range(0, 15));
    endtask

    function automatic logic [21:0] observed();
        return {c1x, c1y, c2x, c2y, best_cnt};
    endfunction

    // ---------------- tests ----------------

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (pt_addr !== 6'd0) begin n_errors++; $display("FAIL reset_pt_addr got %0d want 0", pt_addr); end
        n_checks++; if (observed() !== 22'd0) begin n_errors++; $display("FAIL reset_results got %h want 0", observed()); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single_cluster();
        logic [21:0] exp_res;
        int exp_cyc, cyc, nd;
        logic bad;
        for (int p = 0; p < NPTS; p++) begin mem_x[p] = 4'd5; mem_y[p] = 4'd5; end
        model_run(MAX_PASS, exp_res, exp_cyc);
        launch(cyc, nd, bad);
        n_checks++; if (nd !== 1) begin n_errors++; $display("FAIL cluster_done_pulses got %0d want 1", nd); end
        n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL cluster_busy_at_done got %b want 0", bad); end
        n_checks++; if (observed() !== {4'd5, 4'd1, 4'd0, 4'd0, 6'(NPTS)}) begin
            n_errors++; $display("FAIL cluster_result got %h want %h", observed(), {4'd5, 4'd1, 4'd0, 4'd0, 6'(NPTS)});
        end
        n_checks++; if (cyc !== exp_cyc) begin n_errors++; $display("FAIL cluster_busy_cycles got %0d want %0d", cyc, exp_cyc); end
    endtask

    task automatic test_two_clusters_max_pass();
        logic [21:0] exp_res, exp_res1;
        int exp_cyc, exp_cyc1, cyc, nd, base_cyc, base_done;
        logic bad;
        for (int p = 0; p < NPTS; p++) begin
            mem_x[p] = (p < NPTS / 2) ? 4'd2 : 4'd13;
            mem_y[p] = (p < NPTS / 2) ? 4'd2 : 4'd13;
        end
        model_run(MAX_PASS, exp_res, exp_cyc);
        model_run(1, exp_res1, exp_cyc1);
        base_cyc = mp1_busy_cyc; base_done = mp1_done_cnt;
        launch(cyc, nd, bad);
        n_checks++; if (observed() !== {4'd13, 4'd9, 4'd0, 4'd0, 6'(NPTS)}) begin
            n_errors++; $display("FAIL split_result got %h want %h", observed(), {4'd13, 4'd9, 4'd0, 4'd0, 6'(NPTS)});
        end
        n_checks++; if (cyc !== exp_cyc) begin n_errors++; $display("FAIL split_busy_cycles got %0d want %0d", cyc, exp_cyc); end
        n_checks++; if (nd !== 1) begin n_errors++; $display("FAIL split_done_pulses got %0d want 1", nd); end
        n_checks++; if ({c1x_b, c1y_b, c2x_b, c2y_b, best_cnt_b} !== {4'd13, 4'd9, 4'd0, 4'd0, 6'(NPTS)}) begin
            n_errors++; $display("FAIL maxpass1_result got %h want %h", {c1x_b, c1y_b, c2x_b, c2y_b, best_cnt_b}, {4'd13, 4'd9, 4'd0, 4'd0, 6'(NPTS)});
        end
        n_checks++; if (mp1_busy_cyc - base_cyc !== exp_cyc1) begin
            n_errors++; $display("FAIL maxpass1_busy_cycles got %0d want %0d", mp1_busy_cyc - base_cyc, exp_cyc1);
        end
        n_checks++; if (mp1_done_cnt - base_done !== 1) begin
            n_errors++; $display("FAIL maxpass1_done_pulses got %0d want 1", mp1_done_cnt - base_done);
        end
    endtask

    task automatic test_abort();
        logic [21:0] exp_res;
        int exp_cyc, cyc, nd, stray_done, stray_busy;
        logic bad;
        load_corners();
        model_run(MAX_PASS, exp_res, exp_cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5 * CAND_CYC + 2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_running got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++; if (best_cnt !== 6'd0) begin n_errors++; $display("FAIL abort_best_cnt got %0d want 0", best_cnt); end
        n_checks++; if (observed() !== 22'd0) begin n_errors++; $display("FAIL abort_centers got %h want 0", observed()); end
        n_checks++; if (pt_addr !== 6'd0) begin n_errors++; $display("FAIL abort_pt_addr got %0d want 0", pt_addr); end
        stray_done = (done === 1'b1) ? 1 : 0;
        stray_busy = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) stray_done++;
            if (busy === 1'b1) stray_busy++;
        end
        n_checks++; if (stray_done !== 0) begin n_errors++; $display("FAIL abort_no_done got %0d pulses want 0", stray_done); end
        n_checks++; if (stray_busy !== 0) begin n_errors++; $display("FAIL abort_stays_idle got %0d busy cycles want 0", stray_busy); end
        launch(cyc, nd, bad);
        n_checks++; if (observed() !== exp_res) begin n_errors++; $display("FAIL abort_rerun_result got %h want %h", observed(), exp_res); end
        n_checks++; if (cyc !== exp_cyc) begin n_errors++; $display("FAIL abort_rerun_cycles got %0d want %0d", cyc, exp_cyc); end
        n_checks++; if (nd !== 1) begin n_errors++; $display("FAIL abort_rerun_done_pulses got %0d want 1", nd); end
    endtask

    task automatic test_start_while_busy();
        logic [21:0] exp_res;
        int exp_cyc, cyc, nd;
        logic bad;
        load_corners();
        model_run(MAX_PASS, exp_res, exp_cyc);
        fork
            launch(cyc, nd, bad);
            begin
                repeat (20) @(posedge clk);
                #1; start = 1'b1;
                @(posedge clk); #1; start = 1'b0;
                repeat (600) @(posedge clk);
                #1; start = 1'b1;
                @(posedge clk); #1; start = 1'b0;
                repeat (4000) @(posedge clk);
                #1; start = 1'b1;
                @(posedge clk); #1; start = 1'b0;
            end
        join
        n_checks++; if (nd !== 1) begin n_errors++; $display("FAIL busy_start_done_pulses got %0d want 1", nd); end
        n_checks++; if (cyc !== exp_cyc) begin n_errors++; $display("FAIL busy_start_cycles got %0d want %0d", cyc, exp_cyc); end
        n_checks++; if (observed() !== exp_res) begin n_errors++; $display("FAIL busy_start_result got %h want %h", observed(), exp_res); end
    endtask

    task automatic test_random();
        logic [21:0] exp_res;
        int exp_cyc, cyc, nd;
        logic bad;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NPTS; p++) begin
                mem_x[p] = 4'($urandom_range(0, 15));
                mem_y[p] = 4'($urandom_range(0, 15));
            end
            model_run(MAX_PASS, exp_res, exp_cyc);
            launch(cyc, nd, bad);
            n_checks++; if (observed() !== exp_res) begin n_errors++; $display("FAIL random%0d_result got %h want %h", r, observed(), exp_res); end
            n_checks++; if (cyc !== exp_cyc) begin n_errors++; $display("FAIL random%0d_cycles got %0d want %0d", r, cyc, exp_cyc); end
            n_checks++; if (nd !== 1) begin n_errors++; $display("FAIL random%0d_done_pulses got %0d want 1", r, nd); end
            n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL random%0d_busy_at_done got %b want 0", r, bad); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin mem_x[i] = 4'd0; mem_y[i] = 4'd0; end
        test_reset();
        test_single_cluster();
        test_two_clusters_max_pass();
        test_abort();
        test_start_while_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
